axi_lite_cmd_master: RTL and testbench



---
 rtl/axi_lite_cmd_pkg.sv | 18 +
 rtl/axi_lite_timeout_counter.sv | 30 +++
 rtl/axi_lite_cmd_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_cmd_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_lite_timeout_counter.sv
// Bus-hang watchdog: counts enabled cycles since the last clear and flags the final one.
module axi_lite_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Saturates at LAST so a stalled FSM never wraps back into a fresh window.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Optional bus-hang abort is compiled in with AXI_LITE_CMD_MASTER_TIMEOUT_EN.
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                        rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic [2:0]                  state_dbg
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready are both 1;
  // a valid, once raised, holds with stable payload until its transfer (timeout abort excepted).
  // rsp_valid is a one-cycle strobe with no backpressure.

  state_t                      state, state_nxt;
  logic                        accept, abort, tmo_expired;
  logic                        aw_left, w_left;
  logic                        cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
  logic                        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [AXI_DATA_WIDTH-1:0]   wdata_nxt, rsp_rdata_nxt;
  logic [1:0]                  rsp_resp_nxt;

  assign accept      = cmd_valid && cmd_ready;
  assign m_axi_wstrb = '1;
  assign state_dbg   = state;

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
  axi_lite_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (accept),
    .enable  ((state != IDLE) && (state != DONE)),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_expired        = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    abort           = 1'b0;
    awvalid_nxt     = m_axi_awvalid;
    wvalid_nxt      = m_axi_wvalid;
    bready_nxt      = m_axi_bready;
    arvalid_nxt     = m_axi_arvalid;
    rready_nxt      = m_axi_rready;
    awaddr_nxt      = m_axi_awaddr;
    araddr_nxt      = m_axi_araddr;
    wdata_nxt       = m_axi_wdata;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_resp_nxt    = rsp_resp;
    rsp_timeout_nxt = rsp_timeout;
    aw_left         = m_axi_awvalid && !m_axi_awready;
    w_left          = m_axi_wvalid && !m_axi_wready;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_write) begin
            state_nxt   = WR;
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_ADDR;
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
          end
        end
      end
      WR: begin
        awvalid_nxt = aw_left;
        wvalid_nxt  = w_left;
        if (!aw_left && !w_left) begin
          state_nxt  = WR_RESP;
          bready_nxt = 1'b1;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_nxt       = DONE;
          bready_nxt      = 1'b0;
          rsp_resp_nxt    = m_axi_bresp;
          rsp_rdata_nxt   = '0;
          rsp_timeout_nxt = 1'b0;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_nxt   = RD_DATA;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          state_nxt       = DONE;
          rready_nxt      = 1'b0;
          rsp_resp_nxt    = m_axi_rresp;
          rsp_rdata_nxt   = m_axi_rdata;
          rsp_timeout_nxt = 1'b0;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // A completing handshake has already claimed the cycle, so abort only fires on a stall.
    if (abort) begin
      state_nxt       = DONE;
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_resp_nxt    = RESP_SLVERR;
      rsp_rdata_nxt   = '0;
      rsp_timeout_nxt = 1'b1;
    end

    cmd_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cmd_ready     <= cmd_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      rsp_resp      <= rsp_resp_nxt;
      rsp_timeout   <= rsp_timeout_nxt;
      m_axi_awaddr  <= awaddr_nxt;
      m_axi_awvalid <= awvalid_nxt;
      m_axi_wdata   <= wdata_nxt;
      m_axi_wvalid  <= wvalid_nxt;
      m_axi_bready  <= bready_nxt;
      m_axi_araddr  <= araddr_nxt;
      m_axi_arvalid <= arvalid_nxt;
      m_axi_rready  <= rready_nxt;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed self-checking bench for axi_lite_cmd_master; the timeout scenario follows
// AXI_LITE_CMD_MASTER_TIMEOUT_EN. Inputs change and outputs are sampled 1ns after posedge.
module tb_axi_lite_cmd_master;
  import axi_lite_cmd_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TMO = 16;

  logic          aclk, aresetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic          latch_bit;

  axi_lite_cmd_master #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .state_dbg(state_dbg)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wait_idle cmd_ready=%0b exp=1 after %0d cycles", cmd_ready, n); end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rvalid = 0;
    repeat (3) step();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL rst_axi_valids got=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++; if (m_axi_awaddr !== '0 || m_axi_araddr !== '0 || m_axi_wdata !== '0) begin
      errors++; $display("FAIL rst_addr_data aw=%h ar=%h w=%h exp=0", m_axi_awaddr, m_axi_araddr, m_axi_wdata); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL rst_rsp v=%0b d=%h r=%0d t=%0b exp=all 0", rsp_valid, rsp_rdata, rsp_resp, rsp_timeout); end
    checks++; if (m_axi_wstrb !== 4'hF) begin errors++; $display("FAIL rst_wstrb got=%h exp=f", m_axi_wstrb); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    aresetn = 1'b1;
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got=%0b exp=1", cmd_ready); end
  endtask

  // Read-to-clear status latch: first read sees bit0 set, second sees it cleared.
  task automatic test_read_latch();
    latch_bit = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_idle();
      m_axi_arready = 1; cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0000;
      step(); // T1
      cmd_valid = 0;
      checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 16'h0000) begin errors++; $display("FAIL rd%0d_T1_ar v=%0b a=%h exp v=1 a=0000", k, m_axi_arvalid, m_axi_araddr); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rd%0d_T1_cmd_ready got=%0b exp=0", k, cmd_ready); end
      step(); // T2
      m_axi_arready = 0;
      checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin errors++; $display("FAIL rd%0d_T2 arvalid=%0b rready=%0b exp 0/1", k, m_axi_arvalid, m_axi_rready); end
      m_axi_rvalid = 1; m_axi_rresp = 2'b00; m_axi_rdata = {31'b0, latch_bit};
      latch_bit = 1'b0;
      step(); // T3
      m_axi_rvalid = 0;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd%0d_T3_rsp_valid got=%0b exp=1", k, rsp_valid); end
      checks++; if (rsp_rdata !== ((k == 0) ? 32'h1 : 32'h0) || rsp_resp !== 2'b00) begin
        errors++; $display("FAIL rd%0d_T3_data got=%h/%0d exp=%h/0", k, rsp_rdata, rsp_resp, (k == 0) ? 32'h1 : 32'h0); end
      checks++; if (m_axi_rready !== 1'b0) begin errors++; $display("FAIL rd%0d_T3_rready got=%0b exp=0", k, m_axi_rready); end
      step(); // T4
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rd%0d_T4 rsp_valid=%0b cmd_ready=%0b exp 0/1", k, rsp_valid, cmd_ready); end
    end
  endtask

  task automatic test_write_wready_delay();
    wait_idle();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0004; cmd_wdata = 32'hA5A5A5A5;
    step(); // T1
    cmd_valid = 0; cmd_wdata = 32'h0;
    checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin errors++; $display("FAIL wr_T1_valids aw=%0b w=%0b exp 1/1", m_axi_awvalid, m_axi_wvalid); end
    checks++; if (m_axi_awaddr !== 16'h0004 || m_axi_wdata !== 32'hA5A5A5A5 || m_axi_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_T1_payload a=%h d=%h s=%h exp 0004/a5a5a5a5/f", m_axi_awaddr, m_axi_wdata, m_axi_wstrb); end
    m_axi_awready = 1;
    step(); // T2
    m_axi_awready = 0;
    checks++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b1) begin errors++; $display("FAIL wr_T2 aw=%0b w=%0b exp 0/1", m_axi_awvalid, m_axi_wvalid); end
    step(); // T3
    checks++; if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL wr_T3 w=%0b d=%h exp 1/a5a5a5a5", m_axi_wvalid, m_axi_wdata); end
    step(); // T4
    checks++; if (m_axi_wvalid !== 1'b1 || m_axi_bready !== 1'b0) begin errors++; $display("FAIL wr_T4 w=%0b b=%0b exp 1/0", m_axi_wvalid, m_axi_bready); end
    m_axi_wready = 1;
    step(); // T5
    m_axi_wready = 0;
    checks++; if (m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b1) begin errors++; $display("FAIL wr_T5 w=%0b b=%0b exp 0/1", m_axi_wvalid, m_axi_bready); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    step(); // T6
    m_axi_bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== '0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL wr_T6_rsp v=%0b r=%0d d=%h t=%0b exp 1/0/0/0", rsp_valid, rsp_resp, rsp_rdata, rsp_timeout); end
    step(); // T7
    checks++; if (rsp_valid !== 1'b0 || m_axi_bready !== 1'b0) begin errors++; $display("FAIL wr_T7 rsp_valid=%0b bready=%0b exp 0/0", rsp_valid, m_axi_bready); end
  endtask

  task automatic test_write_w_first();
    wait_idle();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0020; cmd_wdata = 32'h1234_5678;
    step(); // T1
    cmd_valid = 0;
    m_axi_wready = 1;
    step(); // T2
    m_axi_wready = 0;
    checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b0) begin errors++; $display("FAIL wf_T2 aw=%0b w=%0b exp 1/0", m_axi_awvalid, m_axi_wvalid); end
    step(); // T3
    checks++; if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== 16'h0020 || m_axi_bready !== 1'b0) begin
      errors++; $display("FAIL wf_T3 aw=%0b a=%h b=%0b exp 1/0020/0", m_axi_awvalid, m_axi_awaddr, m_axi_bready); end
    m_axi_awready = 1;
    step(); // T4
    m_axi_awready = 0;
    checks++; if (m_axi_awvalid !== 1'b0 || m_axi_bready !== 1'b1) begin errors++; $display("FAIL wf_T4 aw=%0b b=%0b exp 0/1", m_axi_awvalid, m_axi_bready); end
    step(); // T5, responder one cycle late
    checks++; if (m_axi_bready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wf_T5 b=%0b rsp=%0b exp 1/0", m_axi_bready, rsp_valid); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    step(); // T6
    m_axi_bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00) begin errors++; $display("FAIL wf_T6_rsp v=%0b r=%0d exp 1/0", rsp_valid, rsp_resp); end
  endtask

  task automatic test_read_slverr();
    wait_idle();
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0030;
    step(); // T1
    cmd_valid = 0;
    for (int t = 1; t <= 6; t++) begin
      checks++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 16'h0030) begin errors++; $display("FAIL rs_T%0d_ar v=%0b a=%h exp 1/0030", t, m_axi_arvalid, m_axi_araddr); end
      if (t == 6) m_axi_arready = 1;
      step();
    end
    m_axi_arready = 0; // T7
    checks++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin errors++; $display("FAIL rs_T7 ar=%0b r=%0b exp 0/1", m_axi_arvalid, m_axi_rready); end
    m_axi_rvalid = 1; m_axi_rresp = 2'b10; m_axi_rdata = 32'hDEADBEEF;
    step(); // T8
    m_axi_rvalid = 0; m_axi_rresp = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rs_T8_rsp v=%0b r=%0d d=%h exp 1/2/deadbeef", rsp_valid, rsp_resp, rsp_rdata); end
  endtask

  task automatic test_timeout();
    wait_idle();
    m_axi_awready = 0; m_axi_wready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0008; cmd_wdata = 32'h0F0F0F0F;
    step(); // T1
    cmd_valid = 0;
`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    for (int t = 1; t <= TMO; t++) begin
      checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL to_T%0d aw=%0b w=%0b rsp=%0b exp 1/1/0", t, m_axi_awvalid, m_axi_wvalid, rsp_valid); end
      step();
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== '0) begin
      errors++; $display("FAIL to_rsp v=%0b t=%0b r=%0d d=%h exp 1/1/2/0", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
    checks++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 5'b0) begin
      errors++; $display("FAIL to_valids got=%b exp=00000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    step();
    checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_after cmd_ready=%0b rsp=%0b exp 1/0", cmd_ready, rsp_valid); end
`else
    for (int t = 1; t <= 40; t++) begin
      checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL hang_T%0d aw=%0b w=%0b rsp=%0b exp 1/1/0", t, m_axi_awvalid, m_axi_wvalid, rsp_valid); end
      if (t == 40) begin m_axi_awready = 1; m_axi_wready = 1; end
      step();
    end
    m_axi_awready = 0; m_axi_wready = 0;
    checks++; if (m_axi_bready !== 1'b1) begin errors++; $display("FAIL hang_bready got=%0b exp=1", m_axi_bready); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b10;
    step();
    m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b10) begin
      errors++; $display("FAIL hang_rsp v=%0b t=%0b r=%0d exp 1/0/2", rsp_valid, rsp_timeout, rsp_resp); end
`endif
  endtask

  task automatic test_reset_mid();
    wait_idle();
    m_axi_arready = 1; cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0040;
    step(); // T1
    cmd_valid = 0;
    step(); // T2, RD_DATA
    m_axi_arready = 0;
    checks++; if (m_axi_rready !== 1'b1 || m_axi_araddr !== 16'h0040) begin errors++; $display("FAIL rm_T2 rready=%0b a=%h exp 1/0040", m_axi_rready, m_axi_araddr); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (m_axi_rready !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_araddr !== '0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rm_async rready=%0b ar=%0b a=%h cmd_ready=%0b exp all 0", m_axi_rready, m_axi_arvalid, m_axi_araddr, cmd_ready); end
    step();
    aresetn = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_after%0d rsp=%0b cmd_ready=%0b exp 0/1", t, rsp_valid, cmd_ready); end
    end
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h000C; cmd_wdata = 32'h0BADF00D;
    step(); // T1
    cmd_valid = 0;
    checks++; if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1 || m_axi_awaddr !== 16'h000C) begin
      errors++; $display("FAIL rm_wr_T1 aw=%0b w=%0b a=%h exp 1/1/000c", m_axi_awvalid, m_axi_wvalid, m_axi_awaddr); end
    m_axi_awready = 1; m_axi_wready = 1;
    step(); // T2
    m_axi_awready = 0; m_axi_wready = 0;
    checks++; if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b1) begin
      errors++; $display("FAIL rm_wr_T2 aw=%0b w=%0b b=%0b exp 0/0/1", m_axi_awvalid, m_axi_wvalid, m_axi_bready); end
    m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    step(); // T3
    m_axi_bvalid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== '0) begin
      errors++; $display("FAIL rm_wr_T3 v=%0b r=%0d d=%h exp 1/0/0", rsp_valid, rsp_resp, rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int            accepts = 0;
    int            rsps = 0;
    int            last_acc = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] got;
    wait_idle();
    m_axi_arready = 1; cmd_write = 0; cmd_addr = 16'h0010; cmd_valid = 1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) step();
      if (pend) begin
        pend = 1'b0;
        cmd_addr = cmd_addr + 16'h0010;
        if (accepts == 3) cmd_valid = 0;
      end
      if (cmd_valid && cmd_ready) begin
        if (accepts > 0) begin
          checks++; if (cyc - last_acc != 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", cyc - last_acc); end
        end
        last_acc = cyc; accepts++; acc_addr = cmd_addr; pend = 1'b1;
      end
      if (m_axi_arvalid) begin
        checks++; if (m_axi_araddr !== acc_addr || m_axi_rready || m_axi_awvalid || m_axi_wvalid) begin
          errors++; $display("FAIL b2b_ar a=%h exp=%h rready=%0b aw=%0b w=%0b", m_axi_araddr, acc_addr, m_axi_rready, m_axi_awvalid, m_axi_wvalid); end
      end
      if (rsp_valid) begin
        rsps++;
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
        checks++; if (rsp_rdata !== got) begin errors++; $display("FAIL b2b_rdata got=%h exp=%h", rsp_rdata, got); end
      end
      m_axi_rvalid = m_axi_rready;
      if (m_axi_rready) begin
        m_axi_rdata = 32'hB000_0000 + DW'(accepts);
        exp_q.push_back(m_axi_rdata);
      end
    end
    m_axi_rvalid = 0; m_axi_arready = 0;
    checks++; if (accepts != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    checks++; if (rsps != 3 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_rsps got=%0d left=%0d exp 3/0", rsps, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read_latch();
    test_write_wready_delay();
    test_write_w_first();
    test_read_slverr();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
